// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encodings and flag bit positions for alu_pipe.
// The MUL_RUN state only exists when ALU_PIPE_MUL_EN is defined.
package alu_pkg;

  localparam logic [4:0] OP_LD  = 5'h01;
  localparam logic [4:0] OP_ST  = 5'h02;
  localparam logic [4:0] OP_ADD = 5'h03;
  localparam logic [4:0] OP_SUB = 5'h04;
  localparam logic [4:0] OP_AND = 5'h05;
  localparam logic [4:0] OP_OR  = 5'h06;
  localparam logic [4:0] OP_XOR = 5'h07;
  localparam logic [4:0] OP_NOT = 5'h08;
  localparam logic [4:0] OP_SL  = 5'h09;
  localparam logic [4:0] OP_SR  = 5'h0A;
  localparam logic [4:0] OP_SRA = 5'h0B;
  localparam logic [4:0] OP_MUL = 5'h0C;
  localparam logic [4:0] OP_ILL = 5'h1F;

  localparam int FLAG_Z     = 0;
  localparam int FLAG_N     = 1;
  localparam int FLAG_C     = 2;
  localparam int FLAG_V     = 3;
  localparam int FLAG_COUNT = 4;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_t;
`else
  typedef enum logic {
    ST_IDLE = 1'b0
  } state_t;
`endif

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one partial product per cycle for WIDTH cycles.
// o_done and o_product are valid during the final iteration, so the consumer can register them on that edge.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_run;
  logic [2*WIDTH-1:0] w_sum;

  assign w_sum     = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_product = w_sum;
  assign o_done    = r_run && (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU with a registered result and N/Z/C/V flags.
// Define ALU_PIPE_MUL_EN to build in the iterative unsigned multiplier (MUL); otherwise MUL is illegal.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a_bus,
  input  logic [WIDTH-1:0] b_bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bus,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             illegal,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_LIMIT = WIDTH'(WIDTH);

  state_t                r_state;
  logic                  r_out_valid;
  logic [WIDTH-1:0]      r_out_bus;
  logic [FLAG_COUNT-1:0] r_flags;
  logic                  r_illegal;

  logic                  w_accept;
  logic                  w_big_shift;
  logic [SHAMT_W-1:0]    w_shamt;
  logic [WIDTH-1:0]      w_res;
  logic                  w_c;
  logic                  w_v;
  logic                  w_illegal;

  assign in_ready    = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_big_shift = (b_bus >= W_LIMIT);
  assign w_shamt     = b_bus[SHAMT_W-1:0];

  assign out_valid = r_out_valid;
  assign out_bus   = r_out_bus;
  assign z         = r_flags[FLAG_Z];
  assign n         = r_flags[FLAG_N];
  assign c         = r_flags[FLAG_C];
  assign v         = r_flags[FLAG_V];
  assign illegal   = r_illegal;

`ifdef ALU_PIPE_MUL_EN
  logic               r_busy;
  logic               w_is_mul;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_product;

  assign w_is_mul = (opcode == OP_MUL);
  assign busy     = r_busy;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_accept && w_is_mul),
    .i_a       (a_bus),
    .i_b       (b_bus),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );
`else
  assign busy = 1'b0;
`endif

  // Oversized shift amounts saturate instead of wrapping on the low bits.
  always_comb begin
    w_res     = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    w_illegal = 1'b0;
    case (opcode)
      OP_LD, OP_ST: w_res = b_bus;
      OP_ADD: begin
        {w_c, w_res} = {1'b0, a_bus} + {1'b0, b_bus};
        w_v = (a_bus[WIDTH-1] == b_bus[WIDTH-1]) && (w_res[WIDTH-1] != a_bus[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = a_bus - b_bus;
        w_c   = (a_bus < b_bus);
        w_v   = (a_bus[WIDTH-1] != b_bus[WIDTH-1]) && (w_res[WIDTH-1] != a_bus[WIDTH-1]);
      end
      OP_AND: w_res = a_bus & b_bus;
      OP_OR:  w_res = a_bus | b_bus;
      OP_XOR: w_res = a_bus ^ b_bus;
      OP_NOT: w_res = ~a_bus;
      OP_SL:  w_res = w_big_shift ? '0 : (a_bus << w_shamt);
      OP_SR:  w_res = w_big_shift ? '0 : (a_bus >> w_shamt);
      OP_SRA: w_res = w_big_shift ? {WIDTH{a_bus[WIDTH-1]}}
                                  : WIDTH'($signed(a_bus) >>> w_shamt);
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_bus   <= '0;
      r_flags     <= '0;
      r_illegal   <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      r_busy      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
`ifdef ALU_PIPE_MUL_EN
            if (w_is_mul) begin
              r_state     <= ST_MUL_RUN;
              r_busy      <= 1'b1;
              r_out_valid <= 1'b0;
            end else
`endif
            begin
              r_out_bus       <= w_res;
              r_flags[FLAG_Z] <= (w_res == '0);
              r_flags[FLAG_N] <= w_res[WIDTH-1];
              r_flags[FLAG_C] <= w_c;
              r_flags[FLAG_V] <= w_v;
              r_illegal       <= w_illegal;
              r_out_valid     <= 1'b1;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
`ifdef ALU_PIPE_MUL_EN
        // The output register is already empty on entry, since accepting MUL required a free slot.
        ST_MUL_RUN: begin
          if (w_mul_done) begin
            r_out_bus       <= w_mul_product[WIDTH-1:0];
            r_flags[FLAG_Z] <= (w_mul_product[WIDTH-1:0] == '0);
            r_flags[FLAG_N] <= w_mul_product[WIDTH-1];
            r_flags[FLAG_C] <= |w_mul_product[2*WIDTH-1:WIDTH];
            r_flags[FLAG_V] <= 1'b0;
            r_illegal       <= 1'b0;
            r_out_valid     <= 1'b1;
            r_busy          <= 1'b0;
            r_state         <= ST_IDLE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: table-driven vectors through a scoreboard queue plus
// hand-written latency, stall and reset sequences. Follows ALU_PIPE_MUL_EN like the RTL.
`timescale 1ns/1ps
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] a_bus;
  logic [WIDTH-1:0] b_bus;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bus;
  logic             z, n, c, v, illegal, busy;

  typedef struct {
    string            name;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             z, n, c, v, ill;
  } vec_t;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] res;
    logic             z, n, c, v, ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bus   (out_bus),
    .z         (z),
    .n         (n),
    .c         (c),
    .v         (v),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mkExp(input string name, input logic [WIDTH-1:0] res,
                                 input logic ez, en, ec, ev, eill);
    exp_t e;
    e.name = name; e.res = res; e.z = ez; e.n = en; e.c = ec; e.v = ev; e.ill = eill;
    return e;
  endfunction

  task automatic addVec(input string name, input logic [4:0] op, input logic [WIDTH-1:0] a, b, res,
                        input logic ez, en, ec, ev, eill);
    vec_t t;
    t.name = name; t.op = op; t.a = a; t.b = b; t.res = res;
    t.z = ez; t.n = en; t.c = ec; t.v = ev; t.ill = eill;
    vecs.push_back(t);
  endtask

  // Holds the op until accepted, queues its expected result, releases in_valid just after the accept edge.
  task automatic applyStimulus(input string name, input logic [4:0] op, input logic [WIDTH-1:0] a, b,
                               input exp_t e, input bit expectResult);
    int t = 0;
    @(negedge clk);
    opcode = op; a_bus = a; b_bus = b; in_valid = 1'b1;
    #1;
    while (!in_ready && t < 100) begin
      @(negedge clk); #1; t++;
    end
    if (!in_ready) begin
      checkOutput({name, "_accept_timeout"}, 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (expectResult) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard: a result is taken at the next edge when out_valid && out_ready.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_result", {32'd0, out_bus}, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_bus"}, {32'd0, out_bus}, {32'd0, e.res});
        checkOutput({e.name, "_z"}, {63'd0, z}, {63'd0, e.z});
        checkOutput({e.name, "_n"}, {63'd0, n}, {63'd0, e.n});
        checkOutput({e.name, "_c"}, {63'd0, c}, {63'd0, e.c});
        checkOutput({e.name, "_v"}, {63'd0, v}, {63'd0, e.v});
        checkOutput({e.name, "_illegal"}, {63'd0, illegal}, {63'd0, e.ill});
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t none;
    exp_t orExp;
    int   cnt;
    bit   flag;

    none = mkExp("none", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    opcode = '0; a_bus = '0; b_bus = '0; out_ready = 1'b1;
    doReset();

    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_out_bus", {32'd0, out_bus}, 64'd0);
    checkOutput("rst_flags", {60'd0, z, n, c, v}, 64'd0);
    checkOutput("rst_illegal", {63'd0, illegal}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);

    //      name        op      a             b             result        z     n     c     v     ill
    addVec("add_wrap",  OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    addVec("add_ovf",   OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    addVec("sub_ovf",   OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    addVec("sub_borr",  OP_SUB, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    addVec("sub_zero",  OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec("and",       OP_AND, 32'hF0F0A5A5, 32'h0FF0FFFF, 32'h00F0A5A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec("or",        OP_OR,  32'hF0F0A5A5, 32'h0FF0FFFF, 32'hFFF0FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    addVec("xor",       OP_XOR, 32'hF0F0A5A5, 32'h0FF0FFFF, 32'hFF005A5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    addVec("not",       OP_NOT, 32'hF0F0A5A5, 32'h00000000, 32'h0F0F5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec("sl_31",     OP_SL,  32'h00000001, 32'd31,       32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    addVec("sl_32",     OP_SL,  32'h00000001, 32'd32,       32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec("sl_huge",   OP_SL,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec("sra_40",    OP_SRA, 32'h80000000, 32'd40,       32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    addVec("sra_pos",   OP_SRA, 32'h40000000, 32'h00000100, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec("sra_4",     OP_SRA, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    addVec("sr_40",     OP_SR,  32'h80000000, 32'd40,       32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec("sr_4",      OP_SR,  32'hF0000000, 32'd4,        32'h0F000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec("ld",        OP_LD,  32'hDEADBEEF, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec("st",        OP_ST,  32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec("ill_00",    5'h00,  32'h11111111, 32'h22222222, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    addVec("ill_0d",    5'h0D,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`ifndef ALU_PIPE_MUL_EN
    addVec("mul_ill",   OP_MUL, 32'd7,        32'd6,        32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    foreach (vecs[i])
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                    mkExp(vecs[i].name, vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v, vecs[i].ill), 1'b1);

    // Single-cycle latency: valid right after the accept edge, gone one edge later.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("lat_pre_valid", {63'd0, out_valid}, 64'd0);
    applyStimulus("lat_add", OP_ADD, 32'hFFFFFFFF, 32'h1, mkExp("lat_add", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
    checkOutput("lat_add_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    checkOutput("lat_add_valid_clears", {63'd0, out_valid}, 64'd0);

    // Back-to-back stream with a 3-edge output stall after the second result.
    orExp = mkExp("strm_or", 32'hFFF0FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("strm_and", OP_AND, 32'hF0F0A5A5, 32'h0FF0FFFF,
                  mkExp("strm_and", 32'h00F0A5A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    applyStimulus("strm_or", OP_OR, 32'hF0F0A5A5, 32'h0FF0FFFF, orExp, 1'b1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("stall_out_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("stall_out_bus", {32'd0, out_bus}, {32'd0, orExp.res});
      checkOutput("stall_flags", {59'd0, z, n, c, v, illegal}, {59'd0, orExp.z, orExp.n, orExp.c, orExp.v, orExp.ill});
    end
    out_ready = 1'b1;
    applyStimulus("strm_xor", OP_XOR, 32'hF0F0A5A5, 32'h0FF0FFFF,
                  mkExp("strm_xor", 32'hFF005A5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    applyStimulus("strm_not", OP_NOT, 32'hF0F0A5A5, 32'h0,
                  mkExp("strm_not", 32'h0F0F5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    repeat (2) @(negedge clk);

`ifdef ALU_PIPE_MUL_EN
    // MUL: result appears WIDTH edges after the accept edge (single-cycle ops appear after 0).
    applyStimulus("mul_7x6", OP_MUL, 32'd7, 32'd6, mkExp("mul_7x6", 32'd42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    cnt = 0; flag = 1'b0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) flag = 1'b1;
      @(posedge clk); #1; cnt++;
    end
    checkOutput("mul_latency", cnt, WIDTH);
    checkOutput("mul_busy_in_ready", {63'd0, flag}, 64'd0);
    checkOutput("mul_busy_done", {63'd0, busy}, 64'd0);
    applyStimulus("mul_ovf", OP_MUL, 32'h00010000, 32'h00010000,
                  mkExp("mul_ovf", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1; cnt++;
    end
    checkOutput("mul_ovf_latency", cnt, WIDTH);
    repeat (2) @(negedge clk);

    // Reset ten cycles into a multiply aborts it without a result.
    applyStimulus("mul_abort", OP_MUL, 32'd3, 32'd5, none, 1'b0);
    repeat (10) @(posedge clk);
    #1;
`else
    // Without the multiplier MUL is an illegal op with single-cycle latency.
    applyStimulus("mul_ill_lat", OP_MUL, 32'd7, 32'd6, mkExp("mul_ill_lat", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
    checkOutput("mul_ill_latency", {63'd0, out_valid}, 64'd1);
    checkOutput("mul_ill_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);

    // Reset discards a stalled result.
    out_ready = 1'b0;
    applyStimulus("held_abort", OP_ADD, 32'd1, 32'd1, none, 1'b0);
    @(posedge clk); #1;
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("abort_out_bus", {32'd0, out_bus}, 64'd0);
    flag = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (out_valid !== 1'b0) flag = 1'b1;
    end
    checkOutput("abort_no_result", {63'd0, flag}, 64'd0);

    applyStimulus("ill_1f", OP_ILL, 32'hA5A5A5A5, 32'h5A5A5A5A,
                  mkExp("ill_1f", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
    checkOutput("ill_1f_latency", {63'd0, out_valid}, 64'd1);

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
